// File: rtl/cpu_rmw_seq_if.sv
// Bus bundle for the read-modify-write sequencer: CPU request side, memory side and ALU side.
// The sequencer uses the master modport; the CPU/memory/ALU environment uses the slave modport.
interface cpu_rmw_seq_if;
  // CPU request
  logic        start;
  logic [15:0] addr;
  logic [3:0]  op_in;
  logic        carry_in;

  // Memory
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  // Combinational ALU
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        alu_z;
  logic        alu_n;

  // Status and flag update
  logic        busy;
  logic        done;
  logic        flag_we;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  logic        err;

  modport master (
    input  start, addr, op_in, carry_in,
    input  mem_rdata, mem_ready,
    input  alu_result, alu_cout, alu_z, alu_n,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    output alu_op, alu_a, alu_cin,
    output busy, done, flag_we, flag_c, flag_z, flag_n, err
  );

  modport slave (
    output start, addr, op_in, carry_in,
    output mem_rdata, mem_ready,
    output alu_result, alu_cout, alu_z, alu_n,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    input  alu_op, alu_a, alu_cin,
    input  busy, done, flag_we, flag_c, flag_z, flag_n, err
  );
endinterface

// File: rtl/cpu_rmw_seq.sv
// Read-modify-write sequencer for 6502 shift/rotate/inc/dec on memory: read the byte,
// run it through the external ALU, optionally write the original back, then write the result.
module cpu_rmw_seq #(
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cpu_rmw_seq_if.master bus
);

  localparam logic [3:0] OP_ASL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WDUMMY,
    S_WRITE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q,  addr_d;
  logic [3:0]  op_q,    op_d;
  logic        cin_q,   cin_d;
  logic [7:0]  orig_q,  orig_d;
  logic [7:0]  res_q,   res_d;
  logic        c_q,     c_d;
  logic        z_q,     z_d;
  logic        n_q,     n_d;
  logic        err_q,   err_d;

  logic        op_ok;
  logic        keep_carry;

  // The supported codes form one contiguous range, ASL through DEC.
  assign op_ok      = (bus.op_in >= OP_ASL) && (bus.op_in <= OP_DEC);
  assign keep_carry = (op_q == OP_INC) || (op_q == OP_DEC);

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    addr_d         = addr_q;
    op_d           = op_q;
    cin_d          = cin_q;
    orig_d         = orig_q;
    res_d          = res_q;
    c_d            = c_q;
    z_d            = z_q;
    n_d            = n_q;
    err_d          = 1'b0;

    bus.mem_addr   = 16'h0000;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_wdata  = 8'h00;
    bus.alu_op     = 4'h0;
    bus.alu_a      = 8'h00;
    bus.alu_cin    = 1'b0;
    bus.done       = 1'b0;
    bus.flag_we    = 1'b0;
    bus.flag_c     = 1'b0;
    bus.flag_z     = 1'b0;
    bus.flag_n     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_ok) begin
            addr_d  = bus.addr;
            op_d    = bus.op_in;
            cin_d   = bus.carry_in;
            state_d = S_READ;
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      S_READ: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ready) begin
          orig_d  = bus.mem_rdata;
          state_d = S_MODIFY;
        end
      end

      S_MODIFY: begin
        bus.mem_addr = addr_q;
        bus.alu_op   = op_q;
        bus.alu_a    = orig_q;
        bus.alu_cin  = cin_q;
        res_d        = bus.alu_result;
        // INC/DEC leave C untouched, so the flag to load is the carry captured at start.
        c_d          = keep_carry ? cin_q : bus.alu_cout;
        z_d          = bus.alu_z;
        n_d          = bus.alu_n;
        state_d      = DUMMY_WRITE ? S_WDUMMY : S_WRITE;
      end

      S_WDUMMY: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = orig_q;
        if (bus.mem_ready) state_d = S_WRITE;
      end

      S_WRITE: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = res_q;
        if (bus.mem_ready) state_d = S_DONE;
      end

      S_DONE: begin
        bus.done    = 1'b1;
        bus.flag_we = 1'b1;
        bus.flag_c  = c_q;
        bus.flag_z  = z_q;
        bus.flag_n  = n_q;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.err  = err_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      op_q    <= 4'h0;
      cin_q   <= 1'b0;
      orig_q  <= 8'h00;
      res_q   <= 8'h00;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      orig_q  <= orig_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  // Shift/rotate codes between ASL and ROR need no special handling beyond the ALU.
  logic unused_range;
  assign unused_range = (OP_ROR == 4'hA);

endmodule

// File: tb/tb_cpu_rmw_seq.sv
// Scoreboard bench for cpu_rmw_seq: a behavioural ALU and memory surround two instances
// (with and without the dummy write); expected writes and flags are queued at stimulus time.
module tb_cpu_rmw_seq;

  localparam logic [3:0] OP_ASL = 4'h7;
  localparam logic [3:0] OP_LSR = 4'h8;
  localparam logic [3:0] OP_ROL = 4'h9;
  localparam logic [3:0] OP_ROR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_rmw_seq_if bus1();
  cpu_rmw_seq_if bus0();

  cpu_rmw_seq #(.DUMMY_WRITE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cpu_rmw_seq #(.DUMMY_WRITE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Reference ALU: returns {cout, z, n, result}.
  function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic cin);
    logic [7:0] r;
    logic       c;
    r = 8'h00;
    c = 1'b0;
    case (op)
      OP_ASL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_LSR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_ROL: begin r = {a[6:0], cin};  c = a[7]; end
      OP_ROR: begin r = {cin, a[7:1]};  c = a[0]; end
      OP_INC: begin r = a + 8'h01;      c = cin;  end
      OP_DEC: begin r = a - 8'h01;      c = cin;  end
      default: ;
    endcase
    return {c, (r == 8'h00), r[7], r};
  endfunction

  always_comb {bus1.alu_cout, bus1.alu_z, bus1.alu_n, bus1.alu_result} =
    alu_ref(bus1.alu_op, bus1.alu_a, bus1.alu_cin);
  always_comb {bus0.alu_cout, bus0.alu_z, bus0.alu_n, bus0.alu_result} =
    alu_ref(bus0.alu_op, bus0.alu_a, bus0.alu_cin);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } fl_t;

  wr_t exp_wr_q[$];
  fl_t exp_fl_q[$];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rd_data1, rd_data0;
  logic [15:0] cur_addr;
  logic        ready1;
  int          rd_stall, wr_stall, wr_stall_idx;
  int          wr_seen, rd_seen, done_seen;

  assign bus1.mem_rdata = rd_data1;
  assign bus1.mem_ready = ready1;
  assign bus0.mem_rdata = rd_data0;
  assign bus0.mem_ready = 1'b1;

  // Memory model: decides mem_ready for the current cycle once the DUT outputs have settled.
  always @(posedge clk) begin
    #1;
    if (bus1.mem_rd && rd_stall > 0) begin
      ready1   = 1'b0;
      rd_stall = rd_stall - 1;
    end else if (bus1.mem_wr && wr_seen == wr_stall_idx && wr_stall > 0) begin
      ready1   = 1'b0;
      wr_stall = wr_stall - 1;
    end else begin
      ready1   = 1'b1;
    end
  end

  // Monitor on the falling edge: bus rules, completed writes and flag loads against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    fl_t f;
    if (bus1.mem_rd && bus1.mem_wr) begin
      checks++; failures++;
      $display("FAIL rd_wr_overlap: got rd=1 wr=1 expected never both");
    end
    if (bus1.mem_rd || bus1.mem_wr) begin
      checks++;
      if (bus1.mem_addr !== cur_addr) begin
        failures++;
        $display("FAIL mem_addr: got %04h expected %04h", bus1.mem_addr, cur_addr);
      end
    end
    if (bus1.mem_rd && bus1.mem_ready) rd_seen++;
    if (bus1.mem_wr && bus1.mem_ready) begin
      wr_seen++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got %04h<=%02h expected no write", bus1.mem_addr, bus1.mem_wdata);
      end else begin
        e = exp_wr_q.pop_front();
        if ({bus1.mem_addr, bus1.mem_wdata} !== {e.addr, e.data}) begin
          failures++;
          $display("FAIL write: got %04h<=%02h expected %04h<=%02h",
                   bus1.mem_addr, bus1.mem_wdata, e.addr, e.data);
        end
      end
    end
    if (bus1.done) begin
      done_seen++;
      checks++;
      if (exp_fl_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        f = exp_fl_q.pop_front();
        if ({bus1.flag_we, bus1.flag_c, bus1.flag_z, bus1.flag_n} !== {1'b1, f.c, f.z, f.n}) begin
          failures++;
          $display("FAIL flags: got we,c,z,n=%b%b%b%b expected 1%b%b%b",
                   bus1.flag_we, bus1.flag_c, bus1.flag_z, bus1.flag_n, f.c, f.z, f.n);
        end
      end
    end
  end

  function automatic logic [52:0] outs1();
    return {bus1.mem_rd, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata, bus1.busy, bus1.done,
            bus1.flag_we, bus1.flag_c, bus1.flag_z, bus1.flag_n, bus1.err,
            bus1.alu_op, bus1.alu_a, bus1.alu_cin, 6'd0};
  endfunction

  // One full operation on the DUMMY_WRITE=1 instance, with optional memory stalls.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [7:0] d,
                        input logic cin, input int rs, input int ws, input int exp_lat,
                        input logic [7:0] exp_res, input logic ec, input logic ez, input logic en,
                        input string name);
    int   lat;
    logic busy_bad;
    exp_wr_q.push_back('{addr: a, data: d});
    exp_wr_q.push_back('{addr: a, data: exp_res});
    exp_fl_q.push_back('{c: ec, z: ez, n: en});
    cur_addr = a; rd_data1 = d;
    rd_stall = rs; wr_stall = ws; wr_stall_idx = 1; wr_seen = 0;
    @(negedge clk);
    bus1.start = 1'b1; bus1.addr = a; bus1.op_in = op; bus1.carry_in = cin;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    lat = 0; busy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus1.busy) busy_bad = 1'b1;
    end while (!bus1.done && lat < 40);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s_busy: got busy=0 during op expected 1", name);
    end
    @(negedge clk); #1;
    checks++;
    if (exp_wr_q.size() != 0 || exp_fl_q.size() != 0 || bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got wr_left=%0d fl_left=%0d busy=%b expected 0 0 0",
               name, exp_wr_q.size(), exp_fl_q.size(), bus1.busy);
      exp_wr_q.delete(); exp_fl_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.start = 1'b1; bus1.op_in = OP_ASL; bus1.addr = 16'hAAAA;
    bus0.start = 1'b1; bus0.op_in = OP_ASL; bus0.addr = 16'hAAAA;
    repeat (3) @(negedge clk);
    checks++;
    if (outs1() !== 53'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %014h expected 0", outs1());
    end
    rst = 1'b0; bus1.start = 1'b0; bus0.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.busy !== 1'b0 || bus0.busy !== 1'b0 || rd_seen != 0) begin
      failures++;
      $display("FAIL reset_start_ignored: got busy1=%b busy0=%b expected 0 0", bus1.busy, bus0.busy);
    end
  endtask

  task automatic test_asl();
    run_op(OP_ASL, 16'h1234, 8'h81, 1'b0, 0, 0, 5, 8'h02, 1'b1, 1'b0, 1'b0, "asl");
  endtask

  task automatic test_dec_nodummy();
    int         lat, writes;
    logic [7:0] last_wd;
    logic [2:0] fl;
    rd_data0 = 8'h01;
    @(negedge clk);
    bus0.start = 1'b1; bus0.addr = 16'h00F0; bus0.op_in = OP_DEC; bus0.carry_in = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    lat = 0; writes = 0; last_wd = 8'hxx; fl = 3'bxxx;
    do begin
      @(negedge clk);
      lat++;
      if (bus0.mem_wr) begin writes++; last_wd = bus0.mem_wdata; end
      if (bus0.done) fl = {bus0.flag_c, bus0.flag_z, bus0.flag_n};
    end while (!bus0.done && lat < 40);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL dec_latency: got %0d expected 4", lat); end
    checks++;
    if (writes !== 1 || last_wd !== 8'h00) begin
      failures++;
      $display("FAIL dec_write: got %0d writes last=%02h expected 1 write of 00", writes, last_wd);
    end
    checks++;
    if (fl !== 3'b110) begin failures++; $display("FAIL dec_flags: got czn=%b expected 110", fl); end
  endtask

  task automatic test_ror_stall();
    run_op(OP_ROR, 16'hBEEF, 8'h01, 1'b1, 3, 2, 10, 8'h80, 1'b1, 1'b0, 1'b1, "ror_stall");
  endtask

  task automatic test_err();
    int rd0, wr0, busy_hi;
    rd0 = rd_seen; wr0 = wr_seen; busy_hi = 0;
    @(negedge clk);
    bus1.start = 1'b1; bus1.addr = 16'h2222; bus1.op_in = 4'h3; bus1.carry_in = 1'b0;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.err !== 1'b1) begin failures++; $display("FAIL err_pulse: got %b expected 1", bus1.err); end
    if (bus1.busy) busy_hi++;
    @(negedge clk);
    checks++;
    if (bus1.err !== 1'b0) begin failures++; $display("FAIL err_width: got %b expected 0", bus1.err); end
    repeat (3) begin
      @(negedge clk);
      if (bus1.busy || bus1.mem_rd || bus1.mem_wr) busy_hi++;
    end
    checks++;
    if (busy_hi != 0 || rd_seen != rd0 || wr_seen != wr0) begin
      failures++;
      $display("FAIL err_no_access: got busy/access cycles=%0d expected 0", busy_hi);
    end
  endtask

  task automatic test_back_to_back();
    int n, rd0;
    rd0 = rd_seen;
    exp_wr_q.push_back('{addr: 16'h0300, data: 8'hFF});
    exp_wr_q.push_back('{addr: 16'h0300, data: 8'h00});
    exp_fl_q.push_back('{c: 1'b0, z: 1'b1, n: 1'b0});
    cur_addr = 16'h0300; rd_data1 = 8'hFF; wr_seen = 0;
    @(negedge clk);
    bus1.start = 1'b1; bus1.addr = 16'h0300; bus1.op_in = OP_INC; bus1.carry_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus1.addr = 16'h0400 + 16'(n);
    end while (!bus1.done && n < 40);
    bus1.start = 1'b0;
    checks++;
    if (n !== 5) begin failures++; $display("FAIL b2b_latency: got %0d expected 5", n); end
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus1.busy) n++;
    end
    checks++;
    if (n != 0 || rd_seen - rd0 != 1 || exp_wr_q.size() != 0 || exp_fl_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_single_op: got busy_cycles=%0d reads=%0d wr_left=%0d expected 0 1 0",
               n, rd_seen - rd0, exp_wr_q.size());
      exp_wr_q.delete(); exp_fl_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    d0 = done_seen;
    exp_wr_q.push_back('{addr: 16'h4000, data: 8'h55});
    cur_addr = 16'h4000; rd_data1 = 8'h55; wr_seen = 0;
    @(negedge clk);
    bus1.start = 1'b1; bus1.addr = 16'h4000; bus1.op_in = OP_LSR; bus1.carry_in = 1'b0;
    @(posedge clk);
    #1 bus1.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.mem_wr && n < 40);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs1() !== 53'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %014h expected 0", outs1());
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_seen != d0 || exp_wr_q.size() != 0 || bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abandon: got done=%0d wr_left=%0d expected 0 0",
               done_seen - d0, exp_wr_q.size());
      exp_wr_q.delete();
    end
    run_op(OP_LSR, 16'h4000, 8'h55, 1'b0, 0, 0, 5, 8'h2A, 1'b1, 1'b0, 1'b0, "lsr_after_reset");
  endtask

  task automatic test_random_ops();
    logic [3:0]  ops [6];
    logic [10:0] r;
    logic [7:0]  d;
    logic        cin;
    ops = '{OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC};
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      r   = alu_ref(ops[i], d, cin);
      run_op(ops[i], 16'($urandom_range(0, 65535)), d, cin, 0, 0, 5,
             r[7:0], r[10], r[9], r[8], "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus1.start = 1'b0; bus1.addr = 16'h0; bus1.op_in = 4'h0; bus1.carry_in = 1'b0;
    bus0.start = 1'b0; bus0.addr = 16'h0; bus0.op_in = 4'h0; bus0.carry_in = 1'b0;
    rd_data1 = 8'h00; rd_data0 = 8'h00; ready1 = 1'b1; cur_addr = 16'h0;
    rd_stall = 0; wr_stall = 0; wr_stall_idx = 1; wr_seen = 0; rd_seen = 0; done_seen = 0;
    test_reset();
    test_asl();
    test_dec_nodummy();
    test_ror_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_random_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
